// File: rtl/nvram_arb_pkg.sv
// Shared definitions for the NVRAM access arbiter: FSM encoding, requester
// indices and the default write-protect boundary.
package nvram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    WR_ACK  = 2'd3
  } arb_state_e;

  localparam int REQ_BOOT     = 0;
  localparam int REQ_KEYMGMT  = 1;
  localparam int REQ_SECAGENT = 2;

  localparam int ID_W     = 2;
  localparam int TO_CNT_W = 16;

  localparam logic [31:0] WP_LIMIT_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IW'(i) >= ptr)) begin
        any       = 1'b1;
        gnt[i]    = 1'b1;
        gnt_id    = IW'(i);
      end
    end
    // Nothing at or above the pointer: wrap to the lowest index.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        gnt[i]    = 1'b1;
        gnt_id    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/nvram_access_arbiter.sv
// Round-robin, single-outstanding arbiter for the shared NVRAM port with read
// timeout. Optional write protection of the low region: NVRAM_ARB_WRITE_PROTECT_EN.
module nvram_access_arbiter
  import nvram_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 3,
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] WP_LIMIT       = WP_LIMIT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
`ifdef NVRAM_ARB_WRITE_PROTECT_EN
  input  logic                       wp_lock,
`endif
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ-1:0]         rsp_err,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          nvram_rd_addr,
  output logic                       nvram_rd_en,
  input  logic [DATA_W-1:0]          nvram_rd_data,
  input  logic                       nvram_rd_valid,
  output logic [ADDR_W-1:0]          nvram_wr_addr,
  output logic                       nvram_wr_en,
  output logic [DATA_W-1:0]          nvram_wr_data,
  output logic                       busy,
  output logic [1:0]                 grant_id,
  output logic [7:0]                 timeout_count
);

  arb_state_e            state, state_nxt;
  logic [ID_W-1:0]       ptr, id_q, win_id;
  logic [NUM_REQ-1:0]    gnt, id_oh;
  logic                  any_req, accept, timeout_hit, wp_block;
  logic                  we_q, sel_we;
  logic [ADDR_W-1:0]     addr_q, sel_addr;
  logic [DATA_W-1:0]     wdata_q, sel_wdata;
  logic [TO_CNT_W-1:0]   cnt;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (win_id),
    .any    (any_req)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    id_oh     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
      id_oh[i] = (id_q == ID_W'(i));
    end
  end

`ifdef NVRAM_ARB_WRITE_PROTECT_EN
  assign wp_block = wp_lock && sel_we && (sel_addr < ADDR_W'(WP_LIMIT));
`else
  assign wp_block = 1'b0;
`endif

  assign timeout_hit   = (cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign busy          = (state != IDLE);
  assign grant_id      = id_q;
  assign nvram_rd_addr = addr_q;
  assign nvram_wr_addr = addr_q;
  assign nvram_wr_data = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        accept    = any_req;
        if (any_req) state_nxt = wp_block ? WR_ACK : ISSUE;
      end
      ISSUE:   state_nxt = we_q ? WR_ACK : RD_WAIT;
      RD_WAIT: if (nvram_rd_valid || timeout_hit) state_nxt = IDLE;
      WR_ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses and strobes are single-cycle registered pulses; default low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      id_q          <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
      rsp_valid     <= '0;
      rsp_err       <= '0;
      rsp_data      <= '0;
      nvram_rd_en   <= 1'b0;
      nvram_wr_en   <= 1'b0;
      timeout_count <= '0;
    end else begin
      rsp_valid   <= '0;
      rsp_err     <= '0;
      rsp_data    <= '0;
      nvram_rd_en <= 1'b0;
      nvram_wr_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          we_q    <= sel_we;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          id_q    <= win_id;
          cnt     <= '0;
          ptr     <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          if (wp_block) begin
            rsp_valid <= gnt;
            rsp_err   <= gnt;
          end else if (sel_we) begin
            nvram_wr_en <= 1'b1;
          end else begin
            nvram_rd_en <= 1'b1;
          end
        end
        ISSUE: if (we_q) rsp_valid <= id_oh;
        RD_WAIT: begin
          if (nvram_rd_valid) begin
            rsp_valid <= id_oh;
            rsp_data  <= nvram_rd_data;
          end else if (timeout_hit) begin
            rsp_valid <= id_oh;
            rsp_err   <= id_oh;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_access_arbiter.sv
// Scoreboard bench for nvram_access_arbiter: directed commands push expected
// strobes/responses; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_nvram_access_arbiter;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } stb_t;
  typedef struct { int id; bit err; logic [31:0] data; int lat; } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid, req_ready, req_we;
  logic [95:0] req_addr, req_wdata;
  logic [2:0]  rsp_valid, rsp_err;
  logic [31:0] rsp_data, nvram_rd_addr, nvram_rd_data, nvram_wr_addr, nvram_wr_data;
  logic        nvram_rd_en, nvram_rd_valid, nvram_wr_en, busy;
  logic [1:0]  grant_id;
  logic [7:0]  timeout_count;
`ifdef NVRAM_ARB_WRITE_PROTECT_EN
  logic        wp_lock;
`endif

  int   errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
  bit   rsp_en = 1'b1;
  int   rsp_delay = 2;
  cmd_t cmdq [3][$];
  stb_t exp_stb [$];
  rsp_t exp_rsp [$];

  nvram_access_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef NVRAM_ARB_WRITE_PROTECT_EN
    .wp_lock(wp_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .nvram_rd_addr(nvram_rd_addr), .nvram_rd_en(nvram_rd_en),
    .nvram_rd_data(nvram_rd_data), .nvram_rd_valid(nvram_rd_valid),
    .nvram_wr_addr(nvram_wr_addr), .nvram_wr_en(nvram_wr_en),
    .nvram_wr_data(nvram_wr_data), .busy(busy), .grant_id(grant_id),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] nv_data(logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
  endfunction

  task automatic issue(int id, bit we, logic [31:0] addr, logic [31:0] wd,
                       bit stb, bit rsp, bit err, logic [31:0] data, int lat);
    cmdq[id].push_back('{we, addr, wd});
    if (stb) exp_stb.push_back('{we, addr, wd});
    if (rsp) exp_rsp.push_back('{id, err, data, lat});
  endtask

  task automatic drain(int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_rsp.size() + exp_stb.size() + cmdq[0].size() + cmdq[1].size()
          + cmdq[2].size() == 0 && !busy) break;
    end
    chk("drain_pending", exp_rsp.size() + exp_stb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  // Requester driver: hold each head command until its handshake edge.
  initial begin
    logic [2:0] hs;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (hs[i] && reset_n) begin
          void'(cmdq[i].pop_front());
          acc_cyc = cyc;
        end
        if (cmdq[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_we[i]               = cmdq[i][0].we;
          req_addr[i*32 +: 32]    = cmdq[i][0].addr;
          req_wdata[i*32 +: 32]   = cmdq[i][0].wdata;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // NVRAM model: return data rsp_delay cycles after a read strobe.
  initial begin
    int d;
    logic [31:0] v;
    nvram_rd_valid = 1'b0; nvram_rd_data = '0;
    forever begin
      @(negedge clk);
      if (nvram_rd_en && rsp_en && reset_n) begin
        d = rsp_delay;
        v = nv_data(nvram_rd_addr);
        repeat (d) @(posedge clk);
        #1; nvram_rd_valid = 1'b1; nvram_rd_data = v;
        @(posedge clk);
        #1; nvram_rd_valid = 1'b0; nvram_rd_data = '0;
      end
    end
  end

  always @(negedge clk) begin
    stb_t s;
    if (reset_n && (nvram_rd_en || nvram_wr_en)) begin
      chk("strobe_overlap", nvram_rd_en & nvram_wr_en, 0);
      if (exp_stb.size() == 0) chk("strobe_unexpected", {nvram_wr_en, nvram_rd_en}, 0);
      else begin
        s = exp_stb.pop_front();
        chk("strobe_we", nvram_wr_en, s.we);
        if (s.we) begin
          chk("wr_addr", nvram_wr_addr, s.addr);
          chk("wr_data", nvram_wr_data, s.wdata);
        end else chk("rd_addr", nvram_rd_addr, s.addr);
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (reset_n && rsp_valid != 3'b0) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = exp_rsp.pop_front();
        chk("rsp_valid", rsp_valid, 64'(3'b001 << e.id));
        chk("rsp_err", rsp_err, e.err ? 64'(3'b001 << e.id) : 64'd0);
        chk("rsp_data", rsp_data, e.data);
        if (e.lat >= 0) chk("rsp_latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
`ifdef NVRAM_ARB_WRITE_PROTECT_EN
    wp_lock = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_strobes", {nvram_rd_en, nvram_wr_en}, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_timeout_count", timeout_count, 0);
    reset_n = 1'b1;

    // Single read, data two cycles after the strobe.
    issue(1, 0, 32'h40, 0, 1, 1, 0, 32'hDEAD_BEEF, 3);
    drain(50);
    chk("grant_id_read", grant_id, 1);

    // Single write.
    issue(2, 1, 32'h2000, 32'h1234_5678, 1, 1, 0, 0, 1);
    drain(50);
    chk("grant_id_write", grant_id, 2);

    // All three busy: strict rotation 0,1,2,0,1,2.
    issue(0, 0, 32'h100, 0, 1, 1, 0, 32'hC0DE_0100, 3);
    issue(1, 0, 32'h200, 0, 1, 1, 0, 32'hC0DE_0200, 3);
    issue(2, 0, 32'h300, 0, 1, 1, 0, 32'hC0DE_0300, 3);
    issue(0, 0, 32'h104, 0, 1, 1, 0, 32'hC0DE_0104, 3);
    issue(1, 0, 32'h204, 0, 1, 1, 0, 32'hC0DE_0204, 3);
    issue(2, 0, 32'h304, 0, 1, 1, 0, 32'hC0DE_0304, 3);
    drain(200);

    // Data arriving on the last allowed RD_WAIT cycle wins over timeout.
    rsp_delay = 8;
    issue(0, 0, 32'h800, 0, 1, 1, 0, 32'hC0DE_0800, 9);
    drain(50);
    chk("timeout_count_after_late_data", timeout_count, 0);

    // Timeouts, then saturation.
    rsp_en = 1'b0;
    issue(0, 0, 32'h500, 0, 1, 1, 1, 0, 9);
    drain(50);
    chk("timeout_count_one", timeout_count, 1);
    for (int n = 0; n < 299; n++) issue(0, 0, 32'h504, 0, 1, 1, 1, 0, 9);
    drain(5000);
    chk("timeout_count_sat", timeout_count, 255);

    // Reset mid RD_WAIT; the late rd_valid must be ignored.
    rsp_en = 1'b1;
    rsp_delay = 6;
    issue(0, 0, 32'h600, 0, 1, 0, 0, 0, -1);
    for (int k = 0; k < 20 && exp_stb.size() != 0; k++) @(negedge clk);
    chk("reset_test_strobe_seen", exp_stb.size(), 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_timeout_count", timeout_count, 0);
    chk("midreset_grant_id", grant_id, 0);
    chk("midreset_rd_addr", nvram_rd_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_busy", busy, 0);

    // Pointer back to 0: requester 0 wins over 1.
    rsp_delay = 2;
    issue(0, 0, 32'h710, 0, 1, 1, 0, 32'hC0DE_0710, 3);
    issue(1, 0, 32'h700, 0, 1, 1, 0, 32'hC0DE_0700, 3);
    drain(100);

`ifdef NVRAM_ARB_WRITE_PROTECT_EN
    wp_lock = 1'b1;
    issue(0, 1, 32'h0800, 32'hAAAA_0000, 0, 1, 1, 0, 0);
    drain(50);
    issue(0, 1, 32'h1000, 32'hBBBB_0000, 1, 1, 0, 0, 1);
    drain(50);
    wp_lock = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvram_access_arbiter.md
Name: nvram_access_arbiter

Overview:
- Shares the single NVRAM read/write port between the bootloader, key-management and security-agent requesters.
- Replaces the static priority mux with a round-robin, one-outstanding-transaction arbiter.
- Routes each read response only to the requester that issued it.
- A timeout guards against NVRAM responses that never arrive.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = bootloader, 1 = key mgmt, 2 = security agent).
- ADDR_W, 32, NVRAM address width.
- DATA_W, 32, NVRAM data width.
- TIMEOUT_CYCLES, 255, maximum RD_WAIT cycles before a read is aborted (1..65535).
- WP_LIMIT, 32'h0000_1000, upper bound (exclusive) of the write-protected region; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester command accept
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_err  out  NUM_REQ  qualifies rsp_valid; 1 = timeout or protection fault
- rsp_data  out  DATA_W  read data, valid with rsp_valid
- nvram_rd_addr  out  ADDR_W  read address
- nvram_rd_en  out  1  read strobe
- nvram_rd_data  in  DATA_W  read data
- nvram_rd_valid  in  1  read data valid
- nvram_wr_addr  out  ADDR_W  write address
- nvram_wr_en  out  1  write strobe
- nvram_wr_data  out  DATA_W  write data
- busy  out  1  transaction in flight
- grant_id  out  2  index of the current or last granted requester
- timeout_count  out  8  saturating count of timed-out reads

Behaviour:
- Reset (asynchronous, any state, including mid-transaction): FSM goes to IDLE; all outputs 0; round-robin pointer = 0; timeout counter and timeout_count cleared. An in-flight transaction is dropped and no rsp_valid is generated.
- FSM states:
  - IDLE: req_ready is combinational and one-hot for the round-robin winner among req_valid. The search starts at pointer and wraps modulo NUM_REQ. On the edge where valid&ready, latch we/addr/wdata and the winner id, set pointer = winner+1 (wrapping), and go to ISSUE.
  - ISSUE: one cycle; registered nvram_rd_en or nvram_wr_en = 1 with the latched address/data. A read goes to RD_WAIT; a write goes to WR_ACK.
  - RD_WAIT: counter increments each cycle.
    - nvram_rd_valid=1: next cycle rsp_valid[id]=1, rsp_data = captured data, rsp_err=0; go to IDLE.
    - Counter reaches TIMEOUT_CYCLES without valid: rsp_valid[id]=1, rsp_err[id]=1, rsp_data=0; timeout_count+1, saturating at 255; go to IDLE.
    - rd_valid in the same cycle as expiry: data wins, no error.
  - WR_ACK: rsp_valid[id]=1 for one cycle; go to IDLE.
- Strobes: nvram_rd_en/nvram_wr_en are exactly one-cycle pulses and are never both high. Addresses/data are held stable from ISSUE until the return to IDLE.
- nvram_rd_valid in IDLE, ISSUE or WR_ACK is ignored.
- Latency:
  - Read: accept edge T, strobe in T+1, response one cycle after rd_valid.
  - Write: accept T, strobe in T+1, rsp_valid in T+2.
- req_ready is 0 outside IDLE. A requester holds its command stable until accepted. Back-to-back grants are possible on the cycle after a response.
- busy = (state != IDLE). grant_id updates on each accept.

Optional Feature:
- Macro: NVRAM_ARB_WRITE_PROTECT_EN.
- When defined:
  - Adds input port wp_lock (1 bit).
  - An accepted write with addr < WP_LIMIT while wp_lock=1 skips ISSUE: no nvram_wr_en; next cycle rsp_valid[id]=1 with rsp_err[id]=1.
  - Reads are unaffected.
  - wp_lock is sampled on the accept edge.
- When undefined: no port, and all writes are issued.

Decomposition:
- Shared package nvram_arb_pkg holds:
  - FSM state encoding (IDLE, ISSUE, RD_WAIT, WR_ACK).
  - Requester index constants (REQ_BOOT=0, REQ_KEYMGMT=1, REQ_SECAGENT=2).
  - Default WP_LIMIT constant.
- One sub-module, rr_arbiter: combinational round-robin winner select from req vector and pointer, with one-hot grant output. The pointer register lives in the parent.

Test Plan:
- Single read from req 1, addr 0x40; NVRAM returns 0xDEADBEEF two cycles after the strobe -> nvram_rd_en pulse with addr 0x40, rsp_valid=3'b010, rsp_data=0xDEADBEEF, rsp_err=0.
- All three requesters hold req_valid continuously with reads -> grants in order 0,1,2,0,1,2; no strobe overlap; each rsp_valid goes only to its owner.
- Write from req 2, addr 0x2000, data 0x12345678 -> nvram_wr_en one cycle with that addr/data, rsp_valid[2] two cycles after accept, nvram_rd_en stays 0.
- Read with no rd_valid, TIMEOUT_CYCLES=8 -> rsp_err[0]=1 with rsp_data=0 after 8 RD_WAIT cycles, timeout_count=1. Repeat 300 times -> timeout_count saturates at 255.
- reset_n low during RD_WAIT, then rd_valid arriving after release -> no rsp_valid, FSM in IDLE, pointer 0, stray rd_valid ignored.
- With NVRAM_ARB_WRITE_PROTECT_EN, wp_lock=1, write to 0x0800 -> no nvram_wr_en, rsp_err=1. Write to 0x1000 -> normal write.
